// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - data-memory responder: byte-lane word RAM plus LED, cycle counter, TX FIFO and 8N1 serial MMIO
// Reads are combinational from addr; all state changes happen at the rising clk edge.
module dmem_mmio_responder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [3:0]  amp,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic [15:0] led
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_CYCLE  = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_DROP   = 6'h04;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic              ram_sel;
  logic              mmio_sel;
  logic [ADDR_W-1:0] word_idx;
  logic [5:0]        mmio_off;
  logic              unused_addr;

  assign ram_sel     = (addr[31:16] == 16'h0000);
  assign mmio_sel    = (addr[31:8] == 24'hFFFF00);
  assign word_idx    = addr[ADDR_W+1:2];
  assign mmio_off    = addr[7:2];
  assign unused_addr = ^addr;

  logic [31:0] ram_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (amp[i]) ram_q[word_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  logic [15:0]       led_q, led_d;
  logic [31:0]       cycle_q;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        count8;
  logic [7:0]        drop_q, drop_d;
  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              mmio_wr, push, push_ok, pop;
  logic              full, empty, busy, baud_end;

  assign mmio_wr  = memwrite && mmio_sel;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign count8   = 8'(count_q);
  assign baud_end = (baud_q == BAUD_W'(BAUD_DIV - 1));
  assign push     = mmio_wr && (mmio_off == OFF_TXDATA) && amp[0];
  // A push that finds the FIFO full is lost even if the FSM pops this same edge.
  assign push_ok  = push && !full;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= writedata[7:0];
  end

  always_comb begin
    led_d = led_q;
    if (mmio_wr && (mmio_off == OFF_LED)) begin
      if (amp[0]) led_d[7:0]  = writedata[7:0];
      if (amp[1]) led_d[15:8] = writedata[15:8];
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    drop_d = (push && full && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q    <= '0;
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_q + 32'd1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  // Line level follows state directly so reset forces the idle-high level at once.
  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[bit_q];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    readdata = 32'h0;
    if (ram_sel) begin
      readdata = ram_q[word_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
        OFF_LED:    readdata = {16'h0, led_q};
        OFF_CYCLE:  readdata = cycle_q;
        OFF_STATUS: readdata = {16'h0, count8, 5'b0, busy, empty, full};
        OFF_DROP:   readdata = {24'h0, drop_q};
        default:    readdata = 32'h0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - randomized self-checking bench for dmem_mmio_responder
// Behavioural model: word array, byte queue and a frame timeline, compared every cycle.
module tb_dmem_mmio_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int BD     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        memwrite = 1'b0;
  logic [3:0]  amp = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        tx;
  logic [15:0] led;

  dmem_mmio_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset(rst_n), .memwrite(memwrite), .amp(amp), .addr(addr),
    .writedata(writedata), .readdata(readdata), .tx(tx), .led(led)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_ram    [1<<ADDR_W];
  logic [3:0]  m_ram_ok [1<<ADDR_W];
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  logic [7:0]  m_q[$];
  int          m_drop;
  bit          m_active;
  int          m_t;
  logic [7:0]  m_byte;

  bit          tx_log[$];
  logic [31:0] rd_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_led = '0; m_cycle = '0; m_q.delete(); m_drop = 0; m_active = 0; m_t = 0; m_byte = '0;
  endtask

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / BD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  // {valid, data}: RAM words with unwritten bytes are not compared
  function automatic logic [32:0] m_read(input logic [31:0] a);
    int n, idx;
    n = m_q.size();
    if (a[31:16] == 16'h0) begin
      idx = int'((a >> 2) & ((1 << ADDR_W) - 1));
      return {m_ram_ok[idx] == 4'hF, m_ram[idx]};
    end
    if (a[31:8] == 24'hFFFF00) begin
      case (a[7:0] & 8'hFC)
        8'h00:   return {1'b1, 16'h0, m_led};
        8'h04:   return {1'b1, m_cycle};
        8'h0C:   return {1'b1, 16'h0, 8'(n), 5'b0, m_active, n == 0, n == DEPTH};
        8'h10:   return {1'b1, 24'h0, 8'(m_drop)};
        default: return {1'b1, 32'h0};
      endcase
    end
    return {1'b1, 32'h0};
  endfunction

  task automatic model_edge(input bit we, input logic [3:0] a, input logic [31:0] ad, input logic [31:0] wd);
    bit full_pre;
    int idx;
    full_pre = (m_q.size() == DEPTH);
    if (m_active) begin
      m_t++;
      if (m_t == 10*BD) m_active = 0;
    end else if (m_q.size() != 0) begin
      m_byte = m_q.pop_front(); m_active = 1; m_t = 0;
    end
    if (we) begin
      if (ad[31:16] == 16'h0) begin
        idx = int'((ad >> 2) & ((1 << ADDR_W) - 1));
        for (int i = 0; i < 4; i++)
          if (a[i]) begin m_ram[idx][8*i +: 8] = wd[8*i +: 8]; m_ram_ok[idx][i] = 1'b1; end
      end else if (ad[31:8] == 24'hFFFF00) begin
        case (ad[7:0] & 8'hFC)
          8'h00: begin
            if (a[0]) m_led[7:0]  = wd[7:0];
            if (a[1]) m_led[15:8] = wd[15:8];
          end
          8'h08: if (a[0]) begin
            if (full_pre) begin if (m_drop < 255) m_drop++; end
            else m_q.push_back(wd[7:0]);
          end
          default: ;
        endcase
      end
    end
    m_cycle = m_cycle + 32'd1;
  endtask

  task automatic compare_now();
    logic [32:0] r;
    r = m_read(addr);
    if (r[32]) chk("readdata", readdata, r[31:0]);
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    chk("led", {16'b0, led}, {16'b0, m_led});
    tx_log.push_back(tx);
    rd_log.push_back(readdata);
  endtask

  task automatic step(input bit we, input logic [3:0] a, input logic [31:0] ad, input logic [31:0] wd);
    memwrite = we; amp = a; addr = ad; writedata = wd;
    #1 compare_now();
    @(posedge clk);
    if (rst_n) model_edge(we, a, ad, wd);
    @(negedge clk);
  endtask

  task automatic read_lit(input string nm, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; amp = 4'h0; addr = a;
    #1 chk(nm, readdata, exp);
  endtask

  function automatic logic [31:0] rand_ram_addr();
    logic [3:0] al, idx;
    logic [1:0] lo;
    al = 4'($urandom); idx = 4'($urandom); lo = 2'($urandom);
    return {16'h0, al, 6'b0, idx, lo};
  endfunction

  function automatic logic [31:0] rand_mmio_addr();
    logic [7:0] offs [8];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};
    return {24'hFFFF00, offs[$urandom_range(0, 7)] | 8'($urandom_range(0, 3))};
  endfunction

  function automatic logic [31:0] rand_unmapped_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0001_0000 | $urandom;
      1:       return 32'h8000_0000 | $urandom;
      2:       return {16'hFFFE, 16'($urandom)};
      default: return {24'hFFFF01, 8'($urandom)};
    endcase
  endfunction

  int pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    int idx0, busy_n, lows, r;
    int starts[$];
    logic [7:0] ob [10];
    logic [7:0] bv;
    logic [31:0] ad;

    for (int i = 0; i < (1 << ADDR_W); i++) begin m_ram[i] = '0; m_ram_ok[i] = '0; end
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    read_lit("rst_status", 32'hFFFF000C, 32'h0000_0002);
    read_lit("rst_cycle", 32'hFFFF0004, 32'h0);
    rst_n = 1'b1;

    repeat (5) step(0, 4'h0, 32'hFFFF0004, 0);
    read_lit("cycle_after_5", 32'hFFFF0004, 32'd5);

    step(1, 4'hF, 32'h40, 32'h11223344);
    step(1, 4'b0101, 32'h40, 32'hAABBCCDD);
    read_lit("ram_lanes", 32'h40, 32'h11BB33DD);
    read_lit("ram_alias", 32'h40 + (4 << ADDR_W), 32'h11BB33DD);

    step(1, 4'b0010, 32'hFFFF0000, 32'hFFFFBEEF);
    chk("led_lane1", {16'b0, led}, 32'h0000BE00);
    step(1, 4'hF, 32'h80000000, 32'h12345678);
    chk("led_unmapped", {16'b0, led}, 32'h0000BE00);
    read_lit("unmapped_read", 32'h80000000, 32'h0);
    read_lit("ram_unmapped", 32'h40, 32'h11BB33DD);

    for (int i = 0; i < 16; i++) step(1, 4'hF, 32'(i * 4), $urandom);

    // single frame 0xA5; sample after edge E+k sits at log index idx0+1+k
    idx0 = tx_log.size();
    step(1, 4'b0001, 32'hFFFF0008, 32'h000000A5);
    repeat (50) step(0, 4'h0, 32'hFFFF000C, 0);
    chk("frame_pre", {31'b0, tx_log[idx0+1]}, 32'h1);
    chk("frame_start", {31'b0, tx_log[idx0+2]}, 32'h0);
    chk("frame_start_end", {31'b0, tx_log[idx0+5]}, 32'h0);
    for (int j = 0; j < 8; j++) begin
      chk("frame_bit_first", {31'b0, tx_log[idx0+6+4*j]}, 32'(pat[j]));
      chk("frame_bit_last", {31'b0, tx_log[idx0+9+4*j]}, 32'(pat[j]));
    end
    chk("frame_stop", {31'b0, tx_log[idx0+38]}, 32'h1);
    busy_n = 0;
    for (int k = 0; k < 50; k++) busy_n += int'(rd_log[idx0+1+k][2]);
    chk("frame_busy_cycles", 32'(busy_n), 32'd40);
    chk("frame_status_after", rd_log[idx0+50], 32'h0000_0002);

    // overflow: 10 consecutive pushes into an idle, empty FIFO
    for (int i = 0; i < 10; i++) ob[i] = 8'($urandom);
    idx0 = tx_log.size();
    for (int i = 0; i < 10; i++) step(1, 4'b0001, 32'hFFFF0008, {24'h0, ob[i]});
    read_lit("ovf_drop", 32'hFFFF0010, 32'd1);
    read_lit("ovf_status", 32'hFFFF000C, 32'h0000_0805);
    repeat (9*41 + 20) step(0, 4'h0, 32'hFFFF0010, 0);
    for (int k = idx0 + 1; k < tx_log.size() - 40; k++) begin
      if (tx_log[k-1] == 1'b1 && tx_log[k] == 1'b0) begin
        starts.push_back(k);
        k += 39;
      end
    end
    chk("ovf_frames", 32'(starts.size()), 32'd9);
    if (starts.size() > 0) chk("ovf_first_pop", 32'(starts[0] - idx0), 32'd2);
    for (int i = 0; i < starts.size() && i < 9; i++) begin
      for (int j = 0; j < 8; j++) bv[j] = tx_log[starts[i] + 4*(j+1) + 2];
      chk("ovf_byte", {24'h0, bv}, {24'h0, ob[i]});
      chk("ovf_stop", {31'b0, tx_log[starts[i] + 38]}, 32'h1);
      if (i > 0) chk("ovf_period", 32'(starts[i] - starts[i-1]), 32'd41);
    end

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      step(1, 4'($urandom), rand_ram_addr(), $urandom);
      else if (r < 40) step(1, 4'($urandom), {24'hFFFF00, 8'($urandom_range(0, 3))}, $urandom);
      else if (r < 50) step(1, 4'($urandom), {24'hFFFF00, 8'h08 | 8'($urandom_range(0, 3))}, $urandom);
      else if (r < 55) step(1, 4'($urandom), rand_mmio_addr(), $urandom);
      else if (r < 60) step(1, 4'($urandom), rand_unmapped_addr(), $urandom);
      else begin
        case ($urandom_range(0, 2))
          0:       ad = rand_ram_addr();
          1:       ad = rand_mmio_addr();
          default: ad = rand_unmapped_addr();
        endcase
        step(0, 4'($urandom), ad, $urandom);
      end
    end

    for (int i = 0; i < 800 && (m_q.size() != 0 || m_active); i++) step(0, 4'h0, 32'hFFFF000C, 0);
    chk("drain_bound", {31'b0, (m_q.size() == 0 && !m_active)}, 32'h1);

    // reset in the middle of a data bit
    step(1, 4'b0001, 32'hFFFF0008, 32'h0000003C);
    step(1, 4'b0001, 32'hFFFF0008, 32'h000000C3);
    repeat (12) step(0, 4'h0, 32'hFFFF000C, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'b0, tx}, 32'h1);
    chk("midrst_led", {16'b0, led}, 32'h0);
    read_lit("midrst_status", 32'hFFFF000C, 32'h0000_0002);
    read_lit("midrst_cycle", 32'hFFFF0004, 32'h0);
    read_lit("midrst_drop", 32'hFFFF0010, 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idx0 = tx_log.size();
    repeat (60) step(0, 4'h0, 32'hFFFF000C, 0);
    lows = 0;
    for (int k = idx0; k < tx_log.size(); k++) lows += int'(!tx_log[k]);
    chk("postrst_no_frame", 32'(lows), 32'd0);
    read_lit("postrst_status", 32'hFFFF000C, 32'h0000_0002);

    repeat (270) step(1, 4'b0001, 32'hFFFF0008, $urandom);
    read_lit("drop_saturate", 32'hFFFF0010, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
